// File: rtl/prefix_sum_stage.sv
// Final registered stage of the 32-bit prefix adder: forms sum and flags from the tree's
// propagate/carry vectors and hands them downstream through a 2-entry skid buffer.
module prefix_sum_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] gc_in,
  input  logic             c0,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             neg,
  output logic             zero,
  output logic [TAG_W-1:0] tag_out
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             cout;
    logic             ovf;
    logic             neg;
    logic             zero;
    logic [WIDTH-1:0] sum;
  } payload_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e   state_q, state_d;
  payload_t or_q, or_d;
  payload_t sk_q, sk_d;
  payload_t pay;
  logic     in_ready_q, in_ready_d;
  logic     accept, xfer;
  logic [WIDTH-1:0] carry_in, s;

  // Flags are derived from the same payload they travel with.
  always_comb begin
    carry_in = {gc_in[WIDTH-2:0], c0};
    s        = p_in ^ carry_in;
    pay.tag  = tag_in;
    pay.cout = gc_in[WIDTH-1];
    pay.ovf  = gc_in[WIDTH-1] ^ gc_in[WIDTH-2];
    pay.neg  = s[WIDTH-1];
    pay.zero = ~|s;
    pay.sum  = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      or_q       <= '0;
      sk_q       <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      or_q       <= or_d;
      sk_q       <= sk_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign accept = in_valid & in_ready_q;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          or_d    = pay;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          or_d = pay;
        end else if (accept) begin
          sk_d    = pay;
          state_d = StFull;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the drain path applies.
        if (xfer) begin
          or_d    = sk_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StFull);
  end

  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = in_ready_q;
    sum       = or_q.sum;
    cout      = or_q.cout;
    ovf       = or_q.ovf;
    neg       = or_q.neg;
    zero      = or_q.zero;
    tag_out   = or_q.tag;
  end

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Scoreboard bench for prefix_sum_stage: operands are turned into tree vectors, expected results
// come from plain integer addition, and a negedge monitor checks every presented output.
module tb_prefix_sum_stage;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  p_in = '0;
  logic [W-1:0]  gc_in = '0;
  logic          c0 = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout, ovf, neg, zero;
  logic [TW-1:0] tag_out;

  prefix_sum_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .gc_in(gc_in), .c0(c0), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .neg(neg), .zero(zero), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout, ovf, neg, zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: integer addition for the result, per-bit carries for the tree vectors.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic [TW-1:0] tag);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.neg  = e.sum[W-1];
    e.zero = (e.sum == 0);
    e.tag  = tag;
    return e;
  endfunction

  function automatic logic [W-1:0] carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
    logic [W-1:0] g;
    logic [63:0]  mask, part;
    for (int i = 0; i < W; i++) begin
      mask = (64'd1 << (i + 1)) - 64'd1;
      part = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, ci};
      g[i] = part[i+1];
    end
    return g;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic [TW-1:0] tag);
    int waited = 0;
    in_valid = 1'b1;
    p_in     = a ^ b;
    gc_in    = carries(a, b, ci);
    c0       = ci;
    tag_in   = tag;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b, ci, tag));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck 0, expected 1 within 200 cycles");
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check(name, 64'(q.size()), 64'd0);
  endtask

  // Monitor: whatever is presented must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got tag %0d sum %0h, expected no output", tag_out, sum);
      end else begin
        check("sum", 64'(sum), 64'(q[0].sum));
        check("cout", 64'(cout), 64'(q[0].cout));
        check("ovf", 64'(ovf), 64'(q[0].ovf));
        check("neg", 64'(neg), 64'(q[0].neg));
        check("zero", 64'(zero), 64'(q[0].zero));
        check("tag", 64'(tag_out), 64'(q[0].tag));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] corners [4];
    logic [W-1:0] a, b;
    corners[0] = 32'h0; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;

    // Reset with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; p_in = 32'h1234; gc_in = 32'h5678; tag_in = 5'd7;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", 64'({cout, ovf, neg, zero}), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    @(posedge clk); #1;

    // Directed corners with out_ready high.
    out_ready = 1'b1;
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 5'd3);
    @(negedge clk);
    check("ovf_latency", 64'(out_valid), 64'd1);
    check("ovf_sum_direct", 64'(sum), 64'h8000_0000);
    check("ovf_flag_direct", 64'({cout, ovf, neg, zero}), 64'b0110);
    @(posedge clk); #1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 5'd4);
    send(32'd5, 32'd3, 1'b1, 5'd5);
    drain("drain_directed");

    // Backpressure: two accepts fill the stage, then in_ready must drop.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'd10, 32'd20, 1'b0, 5'd1);
    send(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 5'd2);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    fork
      begin
        send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 5'd3);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd4);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset while full discards both entries.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'd1, 32'd2, 1'b0, 5'd9);
    send(32'd3, 32'd4, 1'b0, 5'd10);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstfull_out_valid", 64'(out_valid), 64'd0);
    check("rstfull_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'd100, 32'd23, 1'b0, 5'd11);
    @(negedge clk);
    check("rstfull_latency", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("rstfull_alone", 64'(out_valid), 64'd0);
    drain("drain_rstfull");

    // Randomized traffic with random backpressure and idle gaps.
    @(posedge clk); #1;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
          b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
          send(a, b, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 31)));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_sum_stage.md
Name: prefix_sum_stage

Overview:
- Final, registered stage of the 32-bit prefix adder, directly downstream of the last prefix-tree layer.
- Consumes the per-bit propagate (half-sum) vector and the resolved group-generate (carry) vector from the tree.
- Forms the 32-bit sum plus carry-out, overflow, negative and zero flags, and presents them to the ALU/writeback through a valid/ready interface.
- Contains a 2-entry skid buffer so that backpressure never drops or duplicates a result.

Parameters:
- WIDTH, 32: datapath width; the prefix tree is built for 32.
- TAG_W, 5: width of the sideband tag (destination register index) carried alongside each result.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream presents a result
- in_ready  out  1  stage can accept; registered
- p_in  in  WIDTH  per-bit propagate, a[i]^b[i]
- gc_in  in  WIDTH  group generate; gc_in[i] = carry out of bit i (includes c0)
- c0  in  1  carry into bit 0
- tag_in  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- sum  out  WIDTH  sum
- cout  out  1  carry out of MSB
- ovf  out  1  signed overflow
- neg  out  1  sum[WIDTH-1]
- zero  out  1  sum == 0
- tag_out  out  TAG_W  tag aligned with sum

Behaviour:
- Reset is one clock, synchronous, active-high. On reset: out_valid=0, in_ready=1, skid empty, and sum/cout/ovf/neg/zero/tag_out all cleared to 0. Reset mid-transfer discards all held results.
- Combinational compute on input: carry_in = {gc_in[WIDTH-2:0], c0}; s = p_in ^ carry_in; cout = gc_in[WIDTH-1]; ovf = gc_in[WIDTH-1] ^ gc_in[WIDTH-2]; neg = s[WIDTH-1]; zero = ~|s.
- A payload is the 5-tuple {s, cout, ovf, neg, zero} plus tag. Flags are always computed from the same payload they travel with.
- Accept: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready at a rising edge.
- Storage: output register OR (drives the ports) and skid register SK.
- State encoding: EMPTY (OR invalid), ONE (OR valid, SK empty), FULL (both valid). in_ready = (state != FULL), registered.
- Transitions, all at the clock edge:
  - EMPTY, accept: payload -> OR; go to ONE.
  - ONE, accept and transfer: payload -> OR; stay in ONE.
  - ONE, accept and no transfer: payload -> SK; go to FULL.
  - ONE, transfer and no accept: go to EMPTY.
  - FULL, transfer: SK -> OR; go to ONE. No accept is possible while FULL.
  - FULL, no transfer: hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is one result per cycle under continuous out_ready=1.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- Output payload must be stable while out_valid=1 and out_ready=0.
- in_valid=1 while in_ready=0 is ignored: no capture, no error.
- out_ready may be asserted while out_valid=0; this has no effect.
- Flags ignore WIDTH-1 special cases: WIDTH is at least 2.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all outputs 0 the cycle after rst drops.
- Signed overflow: a=0x7FFFFFFF, b=1, i.e. p_in=0x7FFFFFFE, gc_in=0x7FFFFFFF, c0=0, tag=3, with out_ready=1 -> next cycle sum=0x80000000, cout=0, ovf=1, neg=1, zero=0, tag_out=3.
- Wrap to zero: a=0xFFFFFFFF, b=1, i.e. p_in=0xFFFFFFFE, gc_in=0xFFFFFFFF, c0=0 -> sum=0, cout=1, ovf=0, zero=1, neg=0.
- Carry-in: a=5, b=3, c0=1, i.e. p_in=0x6, gc_in=0x7 -> sum=9, cout=0, ovf=0.
- Backpressure: stream 4 results (tags 1..4) with out_ready=0 -> in_ready drops after the 2nd accept. Then raise out_ready -> tags appear in order 1,2,3,4, each exactly once, with payload held stable throughout the stall.
- Reset while FULL: fill both entries, then assert rst -> out_valid=0, in_ready=1 next cycle; a new input afterwards emerges alone with 1-cycle latency.
